// File: rtl/alu_arith_arbiter.sv
// Two-requester round-robin front end for a shared, registered arithmetic unit.
// One command is in flight at a time: it is accepted in IDLE, issued to the unit
// for one cycle, its result is captured one cycle later, and it is held in RESP
// until the consumer takes it.
module alu_arith_arbiter #(
    parameter int Op_Width = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [Op_Width-1:0] req0_a,
    input  logic [Op_Width-1:0] req0_b,
    input  logic [Op_Width-1:0] req1_a,
    input  logic [Op_Width-1:0] req1_b,
    input  logic [1:0]          req0_fun,
    input  logic [1:0]          req1_fun,
    output logic [Op_Width-1:0] A,
    output logic [Op_Width-1:0] B,
    output logic [1:0]          ALU_FUN,
    output logic                Arith_En,
    input  logic [Op_Width-1:0] Arith_Out,
    input  logic                Carry_Out,
    input  logic                Arith_Flag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [Op_Width-1:0] rsp_data,
    output logic                rsp_carry,
    output logic                rsp_dz
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                dz_pend;
    logic                grant_any;
    logic                grant_id;
    logic [Op_Width-1:0] sel_a;
    logic [Op_Width-1:0] sel_b;
    logic [1:0]          sel_fun;
    logic                sel_dz;

    // The unit's flag is informational only; nothing here reacts to it.
    logic unused_arith_flag;
    assign unused_arith_flag = Arith_Flag;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        sel_a      = grant_id ? req1_a   : req0_a;
        sel_b      = grant_id ? req1_b   : req0_b;
        sel_fun    = grant_id ? req1_fun : req0_fun;
        sel_dz     = (sel_fun == 2'b11) && (sel_b == '0);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (RST && (state == IDLE) && grant_any) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
        end
    end

    // Command sequencing, unit drive and response capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            dz_pend    <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALU_FUN    <= '0;
            Arith_En   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        rsp_id     <= grant_id;
                        dz_pend    <= sel_dz;
                        if (sel_dz) begin
                            // Divide-by-zero bypasses the unit entirely, but
                            // still spends one cycle so the response lands one
                            // edge after acceptance.
                            state <= WAIT;
                        end else begin
                            A        <= sel_a;
                            B        <= sel_b;
                            ALU_FUN  <= sel_fun;
                            Arith_En <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    A        <= '0;
                    B        <= '0;
                    ALU_FUN  <= '0;
                    Arith_En <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_dz    <= dz_pend;
                    rsp_data  <= dz_pend ? '0 : Arith_Out;
                    rsp_carry <= dz_pend ? 1'b0 : Carry_Out;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arith_arbiter.sv
// Bench for alu_arith_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration, latency and arithmetic.
module tb_alu_arith_arbiter;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]   req0_fun = '0, req1_fun = '0;
    logic [W-1:0] A, B;
    logic [1:0]   ALU_FUN;
    logic         Arith_En;
    logic [W-1:0] Arith_Out = '0;
    logic         Carry_Out = 1'b0;
    logic         Arith_Flag = 1'b1;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_carry, rsp_dz;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    alu_arith_arbiter #(.Op_Width(W)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fun(req0_fun), .req1_fun(req1_fun),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_En(Arith_En),
        .Arith_Out(Arith_Out), .Carry_Out(Carry_Out), .Arith_Flag(Arith_Flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_dz(rsp_dz)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Arithmetic unit stand-in: registered one edge after Arith_En.
    logic [2*W-1:0] prod;
    assign prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    always @(posedge CLK) begin
        Arith_Flag <= 1'($urandom_range(0, 1));
        if (Arith_En) begin
            case (ALU_FUN)
                2'b00: {Carry_Out, Arith_Out} <= {1'b0, A} + {1'b0, B};
                2'b01: {Carry_Out, Arith_Out} <= {1'b0, A} - {1'b0, B};
                2'b10: {Carry_Out, Arith_Out} <= prod[W:0];
                default: begin
                    Arith_Out <= (B == '0) ? '0 : A / B;
                    Carry_Out <= 1'b0;
                end
            endcase
        end
    end

    // Expected {carry, data} from plain integer arithmetic.
    function automatic logic [W:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [1:0] f);
        longint ia = longint'(a);
        longint ib = longint'(b);
        longint m  = 65536;
        longint x;
        case (f)
            2'b00: begin x = ia + ib; return {x >= m, W'(x % m)}; end
            2'b01: begin x = (ia - ib + m) % m; return {ia < ib, W'(x)}; end
            2'b10: begin x = ia * ib; return {((x / m) % 2) == 1, W'(x % m)}; end
            default: begin
                if (ib == 0) return '0;
                return {1'b0, W'(ia / ib)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({req0_ready, req1_ready, Arith_En, A, B, ALU_FUN, rsp_valid, rsp_id, rsp_data,
             rsp_carry, rsp_dz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b%b en=%b A=%h B=%h fun=%h v=%b id=%b d=%h c=%b dz=%b required all zero",
                     req0_ready, req1_ready, Arith_En, A, B, ALU_FUN, rsp_valid, rsp_id, rsp_data,
                     rsp_carry, rsp_dz);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [W:0] exp_r;
        int k;
        req0_a = 16'd5;   req0_b = 16'd7;   req0_fun = 2'b01;
        req1_a = 16'd300; req1_b = 16'd300; req1_fun = 2'b10;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            for (k = 0; k < 10 && !(req0_ready || req1_ready); k++) tick();
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant%0d got ready0=%b ready1=%b required grant %0d", i,
                         req0_ready, req1_ready, i % 2);
            end
            tick();
            for (k = 0; k < 10 && !rsp_valid; k++) tick();
            exp_r = (i % 2 == 0) ? {1'b1, 16'hFFFE} : {1'b1, 16'h5F90};
            checks++;
            if ({rsp_valid, rsp_id, rsp_carry, rsp_data, rsp_dz} !== {1'b1, 1'(i % 2), exp_r, 1'b0}) begin
                errors++;
                $display("FAIL rr_rsp%0d got v=%b id=%b c=%b d=%h dz=%b required v=1 id=%0d c=%b d=%h dz=0",
                         i, rsp_valid, rsp_id, rsp_carry, rsp_data, rsp_dz, i % 2, exp_r[W], exp_r[W-1:0]);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_add_carry();
        req0_a = 16'hFFFF; req0_b = 16'h0001; req0_fun = 2'b00;
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_ready got %b%b required 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req0_a = 16'h1234;
        checks++;
        if ({Arith_En, A, B, ALU_FUN, rsp_valid} !== {1'b1, 16'hFFFF, 16'h0001, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL add_issue got en=%b A=%h B=%h fun=%b v=%b required en=1 A=ffff B=0001 fun=00 v=0",
                     Arith_En, A, B, ALU_FUN, rsp_valid);
        end
        tick();
        checks++;
        if ({Arith_En, A, B, ALU_FUN, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL add_wait got en=%b A=%h B=%h fun=%b v=%b required all zero",
                     Arith_En, A, B, ALU_FUN, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp got v=%b id=%b d=%h c=%b dz=%b required v=1 id=0 d=0000 c=1 dz=0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp_done got v=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_div_zero();
        req1_a = 16'd100; req1_b = 16'd0; req1_fun = 2'b11;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL dz_ready got %b%b required 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if ({Arith_En, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL dz_accept got en=%b v=%b required en=0 v=0", Arith_En, rsp_valid);
        end
        tick();
        checks++;
        if ({Arith_En, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz} !== {1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL dz_rsp got en=%b v=%b id=%b d=%h c=%b dz=%b required en=0 v=1 id=1 d=0000 c=0 dz=1",
                     Arith_En, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz);
        end
        tick();
    endtask

    task automatic test_stall();
        int k;
        rsp_ready = 1'b0;
        req0_a = 16'd3; req0_b = 16'd4; req0_fun = 2'b00;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        for (k = 0; k < 10 && !rsp_valid; k++) tick();
        req0_a = 16'd9;  req0_b = 16'd9; req0_fun = 2'b00;
        req1_a = 16'd20; req1_b = 16'd6; req1_fun = 2'b01;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz, req0_ready, req1_ready} !==
                {1'b1, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d got v=%b id=%b d=%h c=%b dz=%b rdy=%b%b required v=1 id=0 d=0007 c=0 dz=0 rdy=00",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz, req0_ready, req1_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stall_regrant got v=%b rdy=%b%b required v=0 rdy=01",
                     rsp_valid, req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (k = 0; k < 10 && !rsp_valid; k++) tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz} !== {1'b1, 1'b1, 16'd14, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_next_rsp got v=%b id=%b d=%h c=%b dz=%b required v=1 id=1 d=000e c=0 dz=0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int k;
        int seen;
        rsp_ready = 1'b1;
        req0_a = 16'd1000; req0_b = 16'd10; req0_fun = 2'b11;
        req0_valid = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, Arith_En, A, B, ALU_FUN, rsp_valid, rsp_id, rsp_data,
             rsp_carry, rsp_dz} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b%b en=%b A=%h B=%h fun=%h v=%b id=%b d=%h c=%b dz=%b required all zero",
                     req0_ready, req1_ready, Arith_En, A, B, ALU_FUN, rsp_valid, rsp_id, rsp_data,
                     rsp_carry, rsp_dz);
        end
        req0_valid = 1'b0;
        tick();
        RST = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_rsp got %0d response cycles required 0", seen);
        end
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        for (k = 0; k < 10 && !rsp_valid; k++) tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz} !== {1'b1, 1'b0, 16'd100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_next got v=%b id=%b d=%h c=%b dz=%b required v=1 id=0 d=0064 c=0 dz=0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dz);
        end
        tick();
    endtask

    task automatic test_random();
        logic         pend = 1'b0, m_ptr = 1'b1, pdz = 1'b0, e_id = 1'b0;
        logic         exp_any, exp_gid, hs, exp_v, exp_en;
        logic [W-1:0] e_a = '0, e_b = '0;
        logic [1:0]   e_fun = '0;
        logic [W:0]   e_r = '0;
        int unsigned  acc_cyc = 0, due = 0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        for (int n = 0; n < 400; n++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = W'($urandom); req1_a = W'($urandom);
            req0_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            req0_fun = 2'($urandom_range(0, 3));
            req1_fun = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_any = !pend && (req0_valid || req1_valid);
            exp_gid = (req0_valid && req1_valid) ? !m_ptr : req1_valid;
            checks++;
            if ({req0_ready, req1_ready} !== {exp_any && !exp_gid, exp_any && exp_gid}) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d got %b%b required %b%b", cyc, req0_ready, req1_ready,
                         exp_any && !exp_gid, exp_any && exp_gid);
            end
            hs = pend && (cyc >= due) && rsp_ready;
            if (exp_any) begin
                e_id  = exp_gid;
                e_a   = exp_gid ? req1_a : req0_a;
                e_b   = exp_gid ? req1_b : req0_b;
                e_fun = exp_gid ? req1_fun : req0_fun;
            end
            tick();
            if (hs) pend = 1'b0;
            if (exp_any) begin
                pend    = 1'b1;
                m_ptr   = e_id;
                acc_cyc = cyc;
                pdz     = (e_fun == 2'b11) && (e_b == '0);
                due     = cyc + (pdz ? 1 : 2);
                e_r     = model_result(e_a, e_b, e_fun);
            end
            exp_v  = pend && (cyc >= due);
            exp_en = pend && !pdz && (cyc == acc_cyc);
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d got %b required %b", cyc, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({rsp_id, rsp_carry, rsp_data, rsp_dz} !== {e_id, e_r, pdz}) begin
                    errors++;
                    $display("FAIL rnd_rsp cyc %0d got id=%b c=%b d=%h dz=%b required id=%b c=%b d=%h dz=%b",
                             cyc, rsp_id, rsp_carry, rsp_data, rsp_dz, e_id, e_r[W], e_r[W-1:0], pdz);
                end
            end
            checks++;
            if ({Arith_En, A, B, ALU_FUN} !== (exp_en ? {1'b1, e_a, e_b, e_fun} : {(2*W+3){1'b0}})) begin
                errors++;
                $display("FAIL rnd_issue cyc %0d got en=%b A=%h B=%h fun=%b required en=%b",
                         cyc, Arith_En, A, B, ALU_FUN, exp_en);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_add_carry();
        test_div_zero();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
